nand3_sweep_sequencer: RTL and testbench

//  Sequencer that drives a 3-input NAND gate through all 8 input combinations.
//  Per vector: wait a settle time, sample the gate output, compare it to the expected value.

---
 rtl/nand3_sweep_pkg.sv | 16 +
 rtl/sweep_settle_timer.sv | 36 +++
 rtl/nand3_sweep_sequencer.sv | 138 +++++++++++++
 tb/tb_nand3_sweep_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand3_sweep_pkg.sv
// Shared types and constants for the 3-input NAND sweep sequencer.
package nand3_sweep_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned NUM_VEC = 8;
    localparam logic [NUM_VEC-1:0] EXPECTED_NAND3 = 8'h7F;
    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSample,
        StDone
    } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: load sets it to 1, it counts while run is high and flags
// expiry once it has been in the run window for SETTLE_CYCLES cycles.
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = run_i && (cnt_q == CNT_W'(SETTLE_CYCLES));

    always_comb begin
        cnt_d = '0;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (run_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nand3_sweep_sequencer.sv
// Walks a 3-input gate through all 8 input vectors, samples its output after a
// settle time and accumulates a truth table, mismatch count and pass flag.
module nand3_sweep_sequencer
    import nand3_sweep_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES = 2,
    parameter logic [NUM_VEC-1:0] EXPECTED      = EXPECTED_NAND3,
    parameter bit                 LOOP          = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               gate_out,
    output logic               gate_a,
    output logic               gate_b,
    output logic               gate_c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] truth_table,
    output logic [3:0]         err_count
);

    sweep_state_e       state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [NUM_VEC-1:0] tt_q, tt_d;
    logic [3:0]         err_q, err_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               timer_load;
    logic               timer_run;
    logic               timer_expire;

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (timer_load),
        .run_i   (timer_run),
        .expire_o(timer_expire)
    );

    assign timer_run = (state_q == StApply);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        tt_d       = tt_q;
        err_d      = err_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        timer_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StApply;
                    idx_d      = '0;
                    vec_d      = '0;
                    tt_d       = '0;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            StApply: begin
                if (timer_expire) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                tt_d[idx_q] = gate_out;
                // Case inequality so an X/Z on the gate output counts as a mismatch.
                if ((gate_out !== EXPECTED[idx_q]) && (err_q != 4'd8)) begin
                    err_d = err_q + 4'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                    vec_d   = '0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d    = StApply;
                    idx_d      = idx_q + VEC_W'(1);
                    vec_d      = idx_q + VEC_W'(1);
                    timer_load = 1'b1;
                end
            end
            StDone: begin
                if (LOOP) begin
                    state_d    = StApply;
                    idx_d      = '0;
                    vec_d      = '0;
                    tt_d       = '0;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            vec_q   <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign gate_a      = vec_q[2];
    assign gate_b      = vec_q[1];
    assign gate_c      = vec_q[0];
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign pass        = pass_q;
    assign truth_table = tt_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_nand3_sweep_sequencer.sv
// Directed bench: a NAND3 primitive with a stuck-at mux drives the default
// sequencer; a second instance (SETTLE_CYCLES=1, LOOP=1) covers auto-restart.
module tb_nand3_sweep_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [1:0] fault_mode;
    logic       nand_y, gate_out;
    logic       gate_a, gate_b, gate_c, busy, done, pass;
    logic [7:0] tt;
    logic [3:0] err;

    logic       rst_n_l, start_l;
    logic       nand_y_l;
    logic       ga_l, gb_l, gc_l, busy_l, done_l, pass_l;
    logic [7:0] tt_l;
    logic [3:0] err_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nand g_nand (nand_y, gate_a, gate_b, gate_c);
    assign gate_out = (fault_mode == 2'd1) ? 1'b1 :
                      (fault_mode == 2'd2) ? 1'b0 : nand_y;

    nand g_nand_l (nand_y_l, ga_l, gb_l, gc_l);

    nand3_sweep_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .gate_out   (gate_out),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .gate_c     (gate_c),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .truth_table(tt),
        .err_count  (err)
    );

    nand3_sweep_sequencer #(
        .SETTLE_CYCLES(1),
        .LOOP         (1'b1)
    ) dut_loop (
        .clk        (clk),
        .rst_n      (rst_n_l),
        .start      (start_l),
        .gate_out   (nand_y_l),
        .gate_a     (ga_l),
        .gate_b     (gb_l),
        .gate_c     (gc_l),
        .busy       (busy_l),
        .done       (done_l),
        .pass       (pass_l),
        .truth_table(tt_l),
        .err_count  (err_l)
    );

    // Accept edge falls between the two negedges; returns in cycle 1 of the sweep.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the sweep cycle (1 = first after accept) in which done is seen, -1 on timeout.
    task automatic wait_done(output int cyc);
        int n;
        cyc = -1;
        n   = 1;
        while (cyc < 0 && n <= 60) begin
            if (done === 1'b1) cyc = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_l = 1'b0;
        start = 1'b0; start_l = 1'b0;
        fault_mode = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gate_a, gate_b, gate_c, busy, done, pass, tt, err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {gate_a, gate_b, gate_c, busy, done, pass, tt, err});
        end
        rst_n = 1'b1; rst_n_l = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_good_sweep();
        int bad_vec = 0;
        int bad_done = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL good_busy: got %b required 1", busy);
        end
        for (int n = 1; n <= 24; n++) begin
            if ({gate_a, gate_b, gate_c} !== 3'((n - 1) / 3)) bad_vec++;
            if (done !== 1'b0) bad_done++;
            @(negedge clk);
        end
        checks++;
        if (bad_vec != 0) begin
            errors++;
            $display("FAIL good_vector_seq: got %0d bad cycles required 0", bad_vec);
        end
        checks++;
        if (bad_done != 0) begin
            errors++;
            $display("FAIL good_early_done: got %0d cycles required 0", bad_done);
        end
        checks++;
        if ({done, busy, pass, tt, err, gate_a, gate_b, gate_c} !== {3'b111, 8'h7F, 4'd0, 3'b000})
        begin
            errors++;
            $display("FAIL good_done_cycle: got done=%b busy=%b pass=%b tt=%h err=%0d gates=%b%b%b required 1 1 1 7f 0 000",
                     done, busy, pass, tt, err, gate_a, gate_b, gate_c);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, pass, tt, err} !== {3'b001, 8'h7F, 4'd0}) begin
            errors++;
            $display("FAIL good_hold_idle: got done=%b busy=%b pass=%b tt=%h err=%0d required 0 0 1 7f 0",
                     done, busy, pass, tt, err);
        end
    endtask

    task automatic test_stuck_faults();
        int cyc;
        fault_mode = 2'd1;
        pulse_start();
        checks++;
        if ({pass, tt, err} !== 13'd0) begin
            errors++;
            $display("FAIL stuck1_clear: got pass=%b tt=%h err=%0d required 0 00 0", pass, tt, err);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 25 || {pass, tt, err} !== {1'b0, 8'hFF, 4'd1}) begin
            errors++;
            $display("FAIL stuck1_result: got cyc=%0d pass=%b tt=%h err=%0d required 25 0 ff 1",
                     cyc, pass, tt, err);
        end
        fault_mode = 2'd2;
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc != 25 || {pass, tt, err} !== {1'b0, 8'h00, 4'd7}) begin
            errors++;
            $display("FAIL stuck0_result: got cyc=%0d pass=%b tt=%h err=%0d required 25 0 00 7",
                     cyc, pass, tt, err);
        end
        fault_mode = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int done_cnt = 0;
        int done_at = -1;
        pulse_start();
        for (int n = 1; n <= 30; n++) begin
            start = (n == 5 || n == 12);
            if (done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done_cnt != 1 || done_at != 25) begin
            errors++;
            $display("FAIL busy_start_ignored: got %0d dones last at %0d required 1 at 25",
                     done_cnt, done_at);
        end
        checks++;
        if ({pass, tt, err} !== {1'b1, 8'h7F, 4'd0}) begin
            errors++;
            $display("FAIL busy_start_result: got pass=%b tt=%h err=%0d required 1 7f 0", pass, tt, err);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int done_seen = 0;
        pulse_start();
        repeat (9) @(negedge clk);
        checks++;
        if ({tt, err} !== {8'h07, 4'd0}) begin
            errors++;
            $display("FAIL midrst_partial: got tt=%h err=%0d required 07 0", tt, err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gate_a, gate_b, gate_c, busy, done, pass, tt, err} !== 17'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b required all zero",
                     {gate_a, gate_b, gate_c, busy, done, pass, tt, err});
        end
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_done: got dones=%0d busy=%b required 0 0", done_seen, busy);
        end
        pulse_start();
        wait_done(cyc);
        checks++;
        if (cyc != 25 || {pass, tt, err} !== {1'b1, 8'h7F, 4'd0}) begin
            errors++;
            $display("FAIL midrst_resweep: got cyc=%0d pass=%b tt=%h err=%0d required 25 1 7f 0",
                     cyc, pass, tt, err);
        end
    endtask

    task automatic test_loop_mode();
        int exp_at = 17;
        int dones = 0;
        @(negedge clk);
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        for (int n = 1; n <= 52; n++) begin
            if (done_l === 1'b1 || n == exp_at) begin
                checks++;
                if (n != exp_at || {done_l, pass_l, tt_l, err_l} !== {2'b11, 8'h7F, 4'd0}) begin
                    errors++;
                    $display("FAIL loop_done: cycle %0d got done=%b pass=%b tt=%h err=%0d required done at %0d with 1 7f 0",
                             n, done_l, pass_l, tt_l, err_l, exp_at);
                end
                if (done_l === 1'b1) dones++;
                exp_at += 17;
            end
            if (n == 18 || n == 35) begin
                checks++;
                if ({tt_l, err_l, busy_l} !== {8'h00, 4'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL loop_clear: cycle %0d got tt=%h err=%0d busy=%b required 00 0 1",
                             n, tt_l, err_l, busy_l);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 3) begin
            errors++;
            $display("FAIL loop_count: got %0d dones required 3", dones);
        end
    endtask

    task automatic test_back_to_back();
        int first_at = -1;
        int second_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 60; n++) begin
            if (done === 1'b1 && first_at < 0) first_at = n;
            else if (done === 1'b1) second_at = n;
            if (n == 26) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle_gap: got busy=%b required 0", busy);
                end
            end
            if (n == 27) begin
                checks++;
                if ({busy, pass, tt, err} !== {1'b1, 1'b0, 8'h00, 4'd0}) begin
                    errors++;
                    $display("FAIL b2b_reaccept: got busy=%b pass=%b tt=%h err=%0d required 1 0 00 0",
                             busy, pass, tt, err);
                end
                start = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (first_at != 25 || second_at != 51 || pass !== 1'b1) begin
            errors++;
            $display("FAIL b2b_dones: got %0d and %0d pass=%b required 25 and 51 pass 1",
                     first_at, second_at, pass);
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_stuck_faults();
        test_start_while_busy();
        test_mid_reset();
        test_loop_mode();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
